// File: rtl/apb_ready_combiner.sv
// ---------------------------------------------------------------------------
// apb_ready_combiner
//
// APB completer-side response combiner for N_CH sub-slave channels. The
// channel index and transfer direction are latched in the SETUP phase; during
// ACCESS only the selected channel's ready strobe for the latched direction
// can complete the transfer. Its PSLVERR and PRDATA are forwarded on
// completion. The block counts wait states and raises a sticky PROT_ERR on
// bus protocol violations or stray ready strobes.
//
// Optional feature (macro APB_READY_TIMEOUT_EN):
//   When defined, an ACCESS phase that has waited TIMEOUT cycles without
//   ready is finished with a forced error response. When undefined, ACCESS
//   waits indefinitely and TIMEOUT is unused.
//
// Parameters:
//   N_CH    number of sub-slave channels (1..16)
//   CH_W    channel index width, 2**CH_W >= N_CH
//   DW      PRDATA width
//   CNT_W   wait-state counter width
//   TIMEOUT wait cycles before a forced error (< 2**CNT_W)
//
// Ports:
//   PCLK          clock, rising edge
//   PRESETn       synchronous active-low reset
//   PSEL/PENABLE  APB phase signals
//   PWRITE        transfer direction, 1 = write
//   CH_SEL        channel index, sampled in SETUP
//   PREADY_R/W    per-channel read / write ready strobes
//   PRDATA_CH     per-channel read data, channel k at [k*DW +: DW]
//   PSLVERR_CH    per-channel error, qualified by that channel's ready
//   PROT_ERR_CLR  clears PROT_ERR (a new violation in the same cycle wins)
//   PREADY        combined ready to the bus
//   PRDATA        combined read data
//   PSLVERR       combined error
//   WAIT_CNT      wait states of the current or last transfer
//   PROT_ERR      sticky protocol-violation flag
// ---------------------------------------------------------------------------
module apb_ready_combiner #(
  parameter int N_CH    = 2,
  parameter int CH_W    = 1,
  parameter int DW      = 32,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [CH_W-1:0]   CH_SEL,
  input  logic [N_CH-1:0]   PREADY_R,
  input  logic [N_CH-1:0]   PREADY_W,
  input  logic [N_CH*DW-1:0] PRDATA_CH,
  input  logic [N_CH-1:0]   PSLVERR_CH,
  input  logic              PROT_ERR_CLR,
  output logic              PREADY,
  output logic [DW-1:0]     PRDATA,
  output logic              PSLVERR,
  output logic [CNT_W-1:0]  WAIT_CNT,
  output logic              PROT_ERR
);

  // Elaboration-time sanity checks on the parameter set.
  if (N_CH < 1 || N_CH > 16 || N_CH > (1 << CH_W)) begin : g_bad_n_ch
    $error("apb_ready_combiner: N_CH must be 1..16 and fit in CH_W bits");
  end
  if (TIMEOUT < 0 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
    $error("apb_ready_combiner: TIMEOUT must be below 2**CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DECERR = 2'd2
  } state_t;

  // N_CH widened by one bit so that N_CH == 2**CH_W is still representable.
  localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

  state_t          state;
  logic [CH_W-1:0] ch_q;
  logic            wr_q;

  logic [N_CH-1:0] sel_onehot;
  logic [DW-1:0]   sel_data;
  logic [N_CH-1:0] exp_r;
  logic [N_CH-1:0] exp_w;
  logic            rdy;
  logic            sel_err;
  logic            stray;
  logic            in_access;
  logic            bus_ok;
  logic            done;
  logic            timeout_hit;
  logic            prot_set;
  logic            ch_valid;

  // Decode the latched channel into a one-hot mask and pick its read data.
  // A loop compare is used instead of a direct index so that an out-of-range
  // ch_q (only possible on the DECERR path) never indexes past the vectors.
  always_comb begin
    sel_onehot = '0;
    sel_data   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        sel_onehot[k] = 1'b1;
        sel_data      = PRDATA_CH[k*DW +: DW];
      end
    end
  end

  // Only the selected channel's strobe for the latched direction is
  // legitimate; every other asserted ready bit in ACCESS is a stray.
  assign exp_r     = wr_q ? '0 : sel_onehot;
  assign exp_w     = wr_q ? sel_onehot : '0;
  assign rdy       = |((wr_q ? PREADY_W : PREADY_R) & sel_onehot);
  assign sel_err   = |(PSLVERR_CH & sel_onehot);
  assign stray     = |((PREADY_R & ~exp_r) | (PREADY_W & ~exp_w));

  assign in_access = (state == ACCESS);
  assign bus_ok    = PSEL & PENABLE;
  assign done      = in_access & bus_ok & rdy;
  assign ch_valid  = ({1'b0, CH_SEL} < N_CH_L);

`ifdef APB_READY_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  // Forced error only when the selected channel is still not ready; a ready
  // arriving in the timeout cycle completes the transfer normally.
  assign timeout_hit = in_access & bus_ok & ~rdy & (WAIT_CNT == TIMEOUT_CNT);
`else
  assign timeout_hit = 1'b0;
`endif

  // Violations: ACCESS-style bus phase while idle, phase signals dropped
  // mid-ACCESS, or any stray ready strobe during ACCESS.
  assign prot_set = ((state == IDLE) & PSEL & PENABLE)
                  | (in_access & ~bus_ok)
                  | (in_access & stray);

  // Bus-facing response. Everything is zero outside ACCESS and DECERR, and
  // read data is only driven on a completing read.
  always_comb begin
    PREADY  = done | timeout_hit | (state == DECERR);
    PSLVERR = (done & sel_err) | timeout_hit | (state == DECERR);
    PRDATA  = (done & ~wr_q) ? sel_data : '0;
  end

  // Transfer FSM with wait counter and sticky protocol error flag.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= IDLE;
      ch_q     <= '0;
      wr_q     <= 1'b0;
      WAIT_CNT <= '0;
      PROT_ERR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            ch_q     <= CH_SEL;
            wr_q     <= PWRITE;
            WAIT_CNT <= '0;
            state    <= ch_valid ? ACCESS : DECERR;
          end
        end
        ACCESS: begin
          if (!bus_ok || rdy || timeout_hit) begin
            state <= IDLE;
          end else if (WAIT_CNT != '1) begin
            WAIT_CNT <= WAIT_CNT + CNT_W'(1);
          end
        end
        DECERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (prot_set) begin
        PROT_ERR <= 1'b1;
      end else if (PROT_ERR_CLR) begin
        PROT_ERR <= 1'b0;
      end
    end
  end

endmodule
